// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT types, constants and component arithmetic helpers
package fft_pkg;

    localparam int DATA_W = 25;
    localparam int TW_W   = 18;

    typedef logic signed [DATA_W-1:0] comp_t;
    typedef logic signed [DATA_W:0]   wide_t;

    typedef struct packed {
        comp_t re;
        comp_t im;
    } cplx_t;

    function automatic cplx_t unpack_cplx(input logic [2*DATA_W-1:0] v);
        return v;
    endfunction

    function automatic logic [2*DATA_W-1:0] pack_cplx(input cplx_t c);
        return c;
    endfunction

    // One guard bit is enough for a sum or difference of two components.
    function automatic wide_t add_comp(input comp_t a, input comp_t b);
        return {a[DATA_W-1], a} + {b[DATA_W-1], b};
    endfunction

    function automatic wide_t sub_comp(input comp_t a, input comp_t b);
        return {a[DATA_W-1], a} - {b[DATA_W-1], b};
    endfunction

    // Overflow shows up as the guard bit disagreeing with the sign bit.
    function automatic comp_t sat_comp(input wide_t v);
        if (v[DATA_W] != v[DATA_W-1]) begin
            return v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
        return v[DATA_W-1:0];
    endfunction

    // Arithmetic shift right by one (floor); the result always fits.
    function automatic comp_t scale_comp(input wide_t v);
        return v[DATA_W:1];
    endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// rtl/sdf_delay_line.sv - enabled shift register with async clear, oldest word at head
module sdf_delay_line #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 50
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Word 0 takes the newest value; word DEPTH-1 is the oldest.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en_i) begin
            mem_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign head_o = mem_q[DEPTH-1];

endmodule

// File: rtl/sdf_butterfly_stage.sv
// rtl/sdf_butterfly_stage.sv - radix-2 SDF butterfly; SDF_BFLY_SCALE_EN selects halving instead of saturation
module sdf_butterfly_stage #(
    parameter  int DELAY  = 16,
    parameter  int DATA_W = fft_pkg::DATA_W,
    localparam int AW     = $clog2(DELAY)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [2*DATA_W-1:0] data_i,
    input  logic                data_valid_i,
    output logic [2*DATA_W-1:0] stage_o,
    output logic [AW-1:0]       w_addr_o,
    output logic                data_valid_o,
    output logic                frame_start_o
);

    import fft_pkg::*;

    typedef logic [AW:0] cnt_t;

    cnt_t                cnt_q, cnt_d;
    logic                primed_q, primed_d;
    logic [2*DATA_W-1:0] stage_q, stage_d;
    logic [AW-1:0]       w_addr_q, w_addr_d;
    logic                valid_q, valid_d;
    logic                fs_q, fs_d;

    logic                phase;
    logic [2*DATA_W-1:0] head;
    logic [2*DATA_W-1:0] dl_d;
    cplx_t               x_c, a_c, sum_c, diff_c;

    function automatic comp_t reduce(input wide_t v);
`ifdef SDF_BFLY_SCALE_EN
        return scale_comp(v);
`else
        return sat_comp(v);
`endif
    endfunction

    sdf_delay_line #(
        .DEPTH (DELAY),
        .WIDTH (2*DATA_W)
    ) u_delay (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (data_valid_i),
        .d_i    (dl_d),
        .head_o (head)
    );

    // Butterfly datapath and next-state: fill phase stores x and drains old differences,
    // compute phase emits a+x and stores a-x for the next frame's fill phase.
    always_comb begin
        phase      = cnt_q[AW];
        x_c        = unpack_cplx(data_i);
        a_c        = unpack_cplx(head);
        sum_c.re   = reduce(add_comp(a_c.re, x_c.re));
        sum_c.im   = reduce(add_comp(a_c.im, x_c.im));
        diff_c.re  = reduce(sub_comp(a_c.re, x_c.re));
        diff_c.im  = reduce(sub_comp(a_c.im, x_c.im));

        dl_d       = phase ? pack_cplx(diff_c) : data_i;
        cnt_d      = cnt_q;
        primed_d   = primed_q;
        stage_d    = stage_q;
        w_addr_d   = w_addr_q;
        valid_d    = 1'b0;
        fs_d       = 1'b0;

        if (data_valid_i) begin
            cnt_d    = cnt_q + cnt_t'(1);
            primed_d = primed_q | (&cnt_q);
            stage_d  = phase ? pack_cplx(sum_c) : head;
            w_addr_d = phase ? '0 : cnt_q[AW-1:0];
            valid_d  = phase | primed_q;
            fs_d     = (cnt_q == cnt_t'(DELAY));
        end
    end

    // Sample counter, priming flag and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            stage_q  <= '0;
            w_addr_q <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            stage_q  <= stage_d;
            w_addr_q <= w_addr_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
        end
    end

    assign stage_o       = stage_q;
    assign w_addr_o      = w_addr_q;
    assign data_valid_o  = valid_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// tb/tb_sdf_butterfly_stage.sv - self-checking bench for sdf_butterfly_stage (DELAY=4)
module tb_sdf_butterfly_stage;

    localparam int     D    = 4;
    localparam int     W    = 25;
    localparam longint MAXV = 16777215;
    localparam longint MINV = -16777216;

    logic           clk = 1'b0;
    logic           rst;
    logic [2*W-1:0] data_i;
    logic           data_valid_i;
    logic [2*W-1:0] stage_o;
    logic [1:0]     w_addr_o;
    logic           data_valid_o;
    logic           frame_start_o;

    int tests = 0;
    int fails = 0;

    sdf_butterfly_stage #(.DELAY(D), .DATA_W(W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_i        (data_i),
        .data_valid_i  (data_valid_i),
        .stage_o       (stage_o),
        .w_addr_o      (w_addr_o),
        .data_valid_o  (data_valid_o),
        .frame_start_o (frame_start_o)
    );

    always #5 clk = ~clk;

    // Expected results for the ramp 1..16 with DELAY=4, imag=0.
    int t_v [16] = '{0,0,0,0, 1,1,1,1, 1,1,1,1, 1,1,1,1};
    int t_w [16] = '{0,0,0,0, 0,0,0,0, 0,1,2,3, 0,0,0,0};
    int t_f [16] = '{0,0,0,0, 1,0,0,0, 0,0,0,0, 1,0,0,0};
`ifdef SDF_BFLY_SCALE_EN
    longint t_d [16] = '{0,0,0,0, 3,4,5,6, -2,-2,-2,-2, 11,12,13,14};
`else
    longint t_d [16] = '{0,0,0,0, 6,8,10,12, -4,-4,-4,-4, 22,24,26,28};
`endif

    // Reference model: a FIFO of D complex values plus a frame position.
    longint q_re[$];
    longint q_im[$];
    int     m_pos;
    bit     m_primed;
    bit     e_v, e_fs;
    longint e_re, e_im;
    int     e_wa;
    longint o_re, o_im;

    function automatic longint red(input longint v);
`ifdef SDF_BFLY_SCALE_EN
        return v >>> 1;
`else
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
`endif
    endfunction

    function automatic longint rnd();
        logic signed [W-1:0] r;
        case ($urandom % 8)
            0: return MAXV;
            1: return MINV;
            default: begin
                r = W'($urandom);
                return longint'(r);
            end
        endcase
    endfunction

    task automatic model_reset();
        q_re.delete();
        q_im.delete();
        for (int i = 0; i < D; i++) begin
            q_re.push_back(0);
            q_im.push_back(0);
        end
        m_pos = 0;
        m_primed = 0;
        e_v = 0;
        e_fs = 0;
    endtask

    task automatic model_step(input bit v, input longint re, input longint im);
        longint hr, hi;
        e_fs = 0;
        if (!v) begin
            e_v = 0;
            return;
        end
        hr = q_re.pop_front();
        hi = q_im.pop_front();
        if (m_pos < D) begin
            e_re = hr; e_im = hi; e_wa = m_pos; e_v = m_primed;
            q_re.push_back(re); q_im.push_back(im);
        end else begin
            e_re = red(hr + re); e_im = red(hi + im); e_wa = 0; e_v = 1;
            e_fs = (m_pos == D);
            q_re.push_back(red(hr - re)); q_im.push_back(red(hi - im));
        end
        m_pos++;
        if (m_pos == 2*D) begin
            m_pos = 0;
            m_primed = 1;
        end
    endtask

    task automatic drive(input bit v, input longint re, input longint im);
        @(negedge clk);
        data_i = {W'(re), W'(im)};
        data_valid_i = v;
        model_step(v, re, im);
        @(posedge clk);
        #1;
        o_re = longint'($signed(stage_o[2*W-1:W]));
        o_im = longint'($signed(stage_o[W-1:0]));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        data_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_valid_i = 1'b0;
        data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (stage_o !== '0) begin fails++; $display("FAIL reset_stage got %h want 0", stage_o); end
        tests++; if (w_addr_o !== 2'd0) begin fails++; $display("FAIL reset_waddr got %0d want 0", w_addr_o); end
        tests++; if (data_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", data_valid_o); end
        tests++; if (frame_start_o !== 1'b0) begin fails++; $display("FAIL reset_fs got %b want 0", frame_start_o); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_ramp();
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i + 1, 0);
            tests++; if (data_valid_o !== 1'(t_v[i])) begin fails++; $display("FAIL ramp_valid[%0d] got %b want %0d", i, data_valid_o, t_v[i]); end
            tests++; if (frame_start_o !== 1'(t_f[i])) begin fails++; $display("FAIL ramp_fs[%0d] got %b want %0d", i, frame_start_o, t_f[i]); end
            if (t_v[i] != 0) begin
                tests++; if (o_re !== t_d[i] || o_im !== 0) begin fails++; $display("FAIL ramp_data[%0d] got %0d/%0d want %0d/0", i, o_re, o_im, t_d[i]); end
                tests++; if (w_addr_o !== 2'(t_w[i])) begin fails++; $display("FAIL ramp_waddr[%0d] got %0d want %0d", i, w_addr_o, t_w[i]); end
            end
        end
    endtask

    task automatic test_gaps();
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i + 1, 0);
            tests++; if (data_valid_o !== 1'(t_v[i])) begin fails++; $display("FAIL gap_valid[%0d] got %b want %0d", i, data_valid_o, t_v[i]); end
            tests++; if (frame_start_o !== 1'(t_f[i])) begin fails++; $display("FAIL gap_fs[%0d] got %b want %0d", i, frame_start_o, t_f[i]); end
            if (t_v[i] != 0) begin
                tests++; if (o_re !== t_d[i] || w_addr_o !== 2'(t_w[i])) begin fails++; $display("FAIL gap_data[%0d] got %0d@%0d want %0d@%0d", i, o_re, w_addr_o, t_d[i], t_w[i]); end
            end
            drive(1'b0, rnd(), rnd());
            tests++; if (data_valid_o !== 1'b0 || frame_start_o !== 1'b0) begin fails++; $display("FAIL gap_idle[%0d] got v=%b fs=%b want 0/0", i, data_valid_o, frame_start_o); end
        end
    endtask

    task automatic test_saturation();
        longint s_re [10] = '{MAXV, MINV, 0, 0, MAXV, 1, 0, 0, 0, 0};
        longint s_im [10] = '{MINV, MAXV, 0, 0, MINV, -1, 0, 0, 0, 0};
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, s_re[i], s_im[i]);
            tests++; if (data_valid_o !== e_v || frame_start_o !== e_fs) begin fails++; $display("FAIL sat_ctrl[%0d] got v=%b fs=%b want v=%b fs=%b", i, data_valid_o, frame_start_o, e_v, e_fs); end
            if (e_v) begin
                tests++; if (o_re !== e_re || o_im !== e_im || w_addr_o !== 2'(e_wa)) begin fails++; $display("FAIL sat_data[%0d] got %0d/%0d@%0d want %0d/%0d@%0d", i, o_re, o_im, w_addr_o, e_re, e_im, e_wa); end
            end
            if (i == 4) begin
                tests++; if (o_re !== MAXV || o_im !== MINV) begin fails++; $display("FAIL sat_sum got %0d/%0d want %0d/%0d", o_re, o_im, MAXV, MINV); end
            end
            if (i == 9) begin
`ifdef SDF_BFLY_SCALE_EN
                tests++; if (o_re !== -64'sd8388609) begin fails++; $display("FAIL sat_diff got %0d want -8388609", o_re); end
`else
                tests++; if (o_re !== MINV || o_im !== MAXV) begin fails++; $display("FAIL sat_diff got %0d/%0d want %0d/%0d", o_re, o_im, MINV, MAXV); end
`endif
            end
        end
    endtask

    task automatic test_reset_midframe();
        reset_dut();
        for (int i = 0; i < 6; i++) drive(1'b1, i + 1, 0);
        tests++; if (data_valid_o !== 1'b1) begin fails++; $display("FAIL mid_prevalid got %b want 1", data_valid_o); end
        @(negedge clk);
        rst = 1'b1;
        data_valid_i = 1'b0;
        #1;
        tests++; if (stage_o !== '0 || w_addr_o !== 2'd0) begin fails++; $display("FAIL mid_async_data got %h@%0d want 0@0", stage_o, w_addr_o); end
        tests++; if (data_valid_o !== 1'b0 || frame_start_o !== 1'b0) begin fails++; $display("FAIL mid_async_ctrl got v=%b fs=%b want 0/0", data_valid_o, frame_start_o); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i + 1, 0);
            tests++; if (data_valid_o !== 1'(t_v[i]) || frame_start_o !== 1'(t_f[i])) begin fails++; $display("FAIL mid_ctrl[%0d] got v=%b fs=%b want %0d/%0d", i, data_valid_o, frame_start_o, t_v[i], t_f[i]); end
            if (t_v[i] != 0) begin
                tests++; if (o_re !== t_d[i]) begin fails++; $display("FAIL mid_data[%0d] got %0d want %0d", i, o_re, t_d[i]); end
            end
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, rnd(), rnd());
            tests++; if (data_valid_o !== e_v || frame_start_o !== e_fs) begin fails++; $display("FAIL rand_ctrl[%0d] got v=%b fs=%b want v=%b fs=%b", i, data_valid_o, frame_start_o, e_v, e_fs); end
            if (e_v) begin
                tests++; if (o_re !== e_re || o_im !== e_im || w_addr_o !== 2'(e_wa)) begin fails++; $display("FAIL rand_data[%0d] got %0d/%0d@%0d want %0d/%0d@%0d", i, o_re, o_im, w_addr_o, e_re, e_im, e_wa); end
            end
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, rnd(), rnd());
            tests++; if (data_valid_o !== e_v || frame_start_o !== e_fs) begin fails++; $display("FAIL b2b_ctrl[%0d] got v=%b fs=%b want v=%b fs=%b", i, data_valid_o, frame_start_o, e_v, e_fs); end
            if (e_v) begin
                tests++; if (o_re !== e_re || o_im !== e_im || w_addr_o !== 2'(e_wa)) begin fails++; $display("FAIL b2b_data[%0d] got %0d/%0d@%0d want %0d/%0d@%0d", i, o_re, o_im, w_addr_o, e_re, e_im, e_wa); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_saturation();
        test_reset_midframe();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
